rv32i_datapath: RTL and testbench
=================================

Name: rv32i_datapath

Overview:
- Execution datapath of a single-cycle RV32I core: PC register, 32x32 register file, immediate generator, ALU, branch comparator, load/store alignment and writeback mux.
- Driven by an external decoder's control strobes; connects to combinational instruction memory and byte-maskable data memory.
- One instruction completes per clock.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- isALUreg  in  1  R-type: ALU operand 2 = rs2.
- regWrite  in  1  enable register file write.
- isJAL  in  1  JAL instruction.
- isJALR  in  1  JALR instruction.
- isBranch  in  1  conditional branch.
- isLUI  in  1  LUI instruction.
- isAUIPC  in  1  AUIPC instruction.
- isLoad  in  1  load instruction.
- isStore  in  1  store instruction.
- isShamt  in  1  shift-immediate: operand 2 = instr[24:20] zero-extended.
- funct3  in  3  instr[14:12]; selects branch condition and load/store width.
- aluControl  in  4  ALU operation select.
- instr  in  32  current instruction word.
- memRdata  in  32  word-aligned data memory read data.
- pc  out  32  current PC; also the instruction fetch address.
- aluOut  out  32  ALU result; also the data memory address.
- memWdata  out  32  store data, lane-shifted.
- aluIn1  out  32  ALU operand 1.
- aluIn2  out  32  ALU operand 2.
- memWMask  out  4  byte write enables.
- isZero  out  1  aluOut == 0.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC; all 32 registers cleared to 0. Other outputs are combinational from instr and state.
- Register fields: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
- Register file reads are combinational. x0 always reads 0.
- Register write occurs on clk rising edge when regWrite=1 and rd!=0. Writes to x0 are discarded.
- Immediates, all sign-extended from instr[31]:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U = {instr[31:12], 12'b0}
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- aluIn1 = rs1 value.
- aluIn2 priority: isALUreg|isBranch -> rs2; isShamt -> {27'b0, instr[24:20]}; isStore -> S-imm; else I-imm.
- aluControl encoding:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT (signed), 0100 SLTU.
  - 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
  - Others -> 0.
  - Shift amount = aluIn2[4:0]. SLT/SLTU yield 0 or 1.
- isZero = (aluOut == 0).
- Branch condition uses a dedicated comparator on rs1/rs2, independent of aluControl. funct3:
  - 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 lt unsigned, 111 ge unsigned.
  - 010/011 never taken.
- Next PC, priority order:
  - isJAL -> pc+J.
  - isJALR -> (rs1+I) & ~1.
  - isBranch & taken -> pc+B.
  - else pc+4.
  - Loaded every rising edge while reset=1. Arithmetic wraps modulo 2^32.
- Load data, selected by funct3 and a=aluOut[1:0]:
  - LB/LBU: byte memRdata[8a+7:8a], sign- or zero-extended.
  - LH/LHU: half selected by a[1], sign- or zero-extended.
  - LW: whole word.
  - Other funct3 values: whole word.
- Store path:
  - memWdata = rs2 << (8*a) for SB; rs2 << (16*a[1]) for SH; rs2 for SW.
  - memWMask (only when isStore=1, else 0000): SB 0001<<a; SH a[1] ? 1100 : 0011; SW 1111.
- Misaligned accesses are not trapped; low address bits beyond the access width are ignored.
- Writeback data, priority: isJAL|isJALR -> pc+4; isLUI -> U; isAUIPC -> pc+U; isLoad -> load data; else aluOut.
- Simultaneous write and read of the same register in one cycle: the read returns the old value, and the new value is visible after the edge.
- Reset asserted mid-instruction: pc and registers clear immediately; any pending write is lost.

Test Plan:
- Reset held low, clk running -> pc=0 and no register changes. Release reset with instr=NOP (0x00000013) -> pc=4, 8, 12 on successive edges.
- ADDI x1,x0,5 (0x00500093), regWrite=1, aluControl=ADD -> aluIn2=5, aluOut=5, isZero=0. Next edge: x1=5, pc+=4.
- With x1=5, x2=5: BEQ x1,x2,+8 (0x00208463), isBranch=1, funct3=000, aluControl=SUB -> isZero=1 and pc advances by 8. With x2=6 -> pc+4.
- JAL x1,+16 (0x010000EF) at pc=0x20 -> x1=0x24, pc=0x30. JALR x0,0(x1) -> pc=0x24, no register write.
- SB x2,1(x0) with x2=0xAB -> aluOut=1, memWMask=0010, memWdata=0x0000AB00. SW -> memWMask=1111. Non-store -> memWMask=0000.
- LB x3,3(x0), memRdata=0x80000000, funct3=000 -> x3=0xFFFFFF80. LBU -> x3=0x00000080. LUI x4,0x12345 -> x4=0x12345000. regWrite with rd=x0 -> x0 still reads 0.

Source files
------------

// File: rtl/rv32i_datapath.sv
// rv32i_datapath: single-cycle RV32I execution datapath (PC, register file, immediates, ALU,
// branch compare, load/store lane alignment, writeback).
module rv32i_datapath #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_is_alu_reg,
   input  logic        i_reg_write,
   input  logic        i_is_jal,
   input  logic        i_is_jalr,
   input  logic        i_is_branch,
   input  logic        i_is_lui,
   input  logic        i_is_auipc,
   input  logic        i_is_load,
   input  logic        i_is_store,
   input  logic        i_is_shamt,
   input  logic [2:0]  i_funct3,
   input  logic [3:0]  i_alu_control,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_mem_rdata,
   output logic [31:0] o_pc,
   output logic [31:0] o_alu_out,
   output logic [31:0] o_mem_wdata,
   output logic [31:0] o_alu_in1,
   output logic [31:0] o_alu_in2,
   output logic [3:0]  o_mem_wmask,
   output logic        o_is_zero
);
   logic [31:0] r_pc;
   logic [31:0] r_regs [0:31];
   logic [4:0]  w_rd;
   logic [31:0] w_rs1, w_rs2;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic [31:0] w_alu_in2, w_alu_out;
   logic [4:0]  w_shamt;
   logic        w_eq, w_lt, w_ltu, w_taken;
   logic [31:0] w_pc4, w_pc_next, w_load, w_wb;
   logic [1:0]  w_a;
   logic [7:0]  w_lbyte;
   logic [15:0] w_lhalf;
   logic        w_unused;

   assign w_rd    = i_instr[11:7];
   assign w_rs1   = r_regs[i_instr[19:15]];
   assign w_rs2   = r_regs[i_instr[24:20]];
   assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
   assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign w_imm_b = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
   assign w_imm_u = {i_instr[31:12], 12'b0};
   assign w_imm_j = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

   assign w_alu_in2 = (i_is_alu_reg || i_is_branch) ? w_rs2 :
                      i_is_shamt ? {27'b0, i_instr[24:20]} :
                      i_is_store ? w_imm_s : w_imm_i;
   assign w_shamt   = w_alu_in2[4:0];

   always_comb begin
      w_alu_out = 32'd0;
      case (i_alu_control)
         4'd0: w_alu_out = w_rs1 + w_alu_in2;
         4'd1: w_alu_out = w_rs1 - w_alu_in2;
         4'd2: w_alu_out = w_rs1 << w_shamt;
         4'd3: w_alu_out = {31'b0, $signed(w_rs1) < $signed(w_alu_in2)};
         4'd4: w_alu_out = {31'b0, w_rs1 < w_alu_in2};
         4'd5: w_alu_out = w_rs1 ^ w_alu_in2;
         4'd6: w_alu_out = w_rs1 >> w_shamt;
         4'd7: w_alu_out = $signed(w_rs1) >>> w_shamt;
         4'd8: w_alu_out = w_rs1 | w_alu_in2;
         4'd9: w_alu_out = w_rs1 & w_alu_in2;
         default: w_alu_out = 32'd0;
      endcase
   end

   // branch decision uses its own comparator so aluControl is free for the decoder
   assign w_eq    = w_rs1 == w_rs2;
   assign w_lt    = $signed(w_rs1) < $signed(w_rs2);
   assign w_ltu   = w_rs1 < w_rs2;
   assign w_taken = (i_funct3 == 3'b000) ? w_eq :
                    (i_funct3 == 3'b001) ? !w_eq :
                    (i_funct3 == 3'b100) ? w_lt :
                    (i_funct3 == 3'b101) ? !w_lt :
                    (i_funct3 == 3'b110) ? w_ltu :
                    (i_funct3 == 3'b111) ? !w_ltu : 1'b0;

   assign w_pc4     = r_pc + 32'd4;
   assign w_pc_next = i_is_jal ? r_pc + w_imm_j :
                      i_is_jalr ? (w_rs1 + w_imm_i) & ~32'd1 :
                      (i_is_branch && w_taken) ? r_pc + w_imm_b : w_pc4;

   assign w_a     = w_alu_out[1:0];
   assign w_lbyte = 8'(i_mem_rdata >> {w_a, 3'b000});
   assign w_lhalf = w_a[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
   assign w_load  = (i_funct3 == 3'b000) ? {{24{w_lbyte[7]}}, w_lbyte} :
                    (i_funct3 == 3'b100) ? {24'b0, w_lbyte} :
                    (i_funct3 == 3'b001) ? {{16{w_lhalf[15]}}, w_lhalf} :
                    (i_funct3 == 3'b101) ? {16'b0, w_lhalf} : i_mem_rdata;

   assign o_mem_wdata = (i_funct3[1:0] == 2'b00) ? w_rs2 << {w_a, 3'b000} :
                        (i_funct3[1:0] == 2'b01) ? w_rs2 << {w_a[1], 4'b0000} : w_rs2;
   assign o_mem_wmask = !i_is_store ? 4'b0000 :
                        (i_funct3[1:0] == 2'b00) ? 4'b0001 << w_a :
                        (i_funct3[1:0] == 2'b01) ? (w_a[1] ? 4'b1100 : 4'b0011) : 4'b1111;

   assign w_wb = (i_is_jal || i_is_jalr) ? w_pc4 :
                 i_is_lui ? w_imm_u :
                 i_is_auipc ? r_pc + w_imm_u :
                 i_is_load ? w_load : w_alu_out;

   // x0 is cleared on reset and never written, so it always reads zero
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc <= RESET_PC;
         for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
      end else begin
         r_pc <= w_pc_next;
         if (i_reg_write && w_rd != 5'd0) r_regs[w_rd] <= w_wb;
      end
   end

   assign o_pc      = r_pc;
   assign o_alu_out = w_alu_out;
   assign o_alu_in1 = w_rs1;
   assign o_alu_in2 = w_alu_in2;
   assign o_is_zero = w_alu_out == 32'd0;
   assign w_unused  = ^i_instr[6:0];
endmodule

// File: tb/tb_rv32i_datapath.sv
// tb_rv32i_datapath: executes directed and random RV32I instructions against an
// instruction-level reference model of architectural state.
module tb_rv32i_datapath;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        is_alu_reg, reg_write, is_jal, is_jalr, is_branch, is_lui, is_auipc;
   logic        is_load, is_store, is_shamt;
   logic [2:0]  funct3;
   logic [3:0]  alu_control;
   logic [31:0] instr, mem_rdata;
   logic [31:0] pc, alu_out, mem_wdata, alu_in1, alu_in2;
   logic [3:0]  mem_wmask;
   logic        is_zero;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] m_regs [32];
   logic [31:0] m_pc;
   logic [31:0] s_in1, s_in2, s_alu, s_wd;
   logic [3:0]  s_mask;
   logic        s_zero;

   rv32i_datapath #(.RESET_PC(32'h0)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_is_alu_reg(is_alu_reg), .i_reg_write(reg_write),
      .i_is_jal(is_jal), .i_is_jalr(is_jalr), .i_is_branch(is_branch), .i_is_lui(is_lui),
      .i_is_auipc(is_auipc), .i_is_load(is_load), .i_is_store(is_store), .i_is_shamt(is_shamt),
      .i_funct3(funct3), .i_alu_control(alu_control), .i_instr(instr), .i_mem_rdata(mem_rdata),
      .o_pc(pc), .o_alu_out(alu_out), .o_mem_wdata(mem_wdata), .o_alu_in1(alu_in1),
      .o_alu_in2(alu_in2), .o_mem_wmask(mem_wmask), .o_is_zero(is_zero)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] op_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (f3)
         3'd0: r = alt ? a - b : a + b;
         3'd1: r = a << b[4:0];
         3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: r = (a < b) ? 32'd1 : 32'd0;
         3'd4: r = a ^ b;
         3'd5: if (alt) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
         3'd6: r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ld_ref(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d);
      logic [7:0]  by;
      logic [15:0] h;
      by = d[8*a +: 8];
      h  = d[16*a[1] +: 16];
      case (f3)
         3'd0: return {{24{by[7]}}, by};
         3'd4: return {24'd0, by};
         3'd1: return {{16{h[15]}}, h};
         3'd5: return {16'd0, h};
         default: return d;
      endcase
   endfunction

   function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0: return alt ? 4'd1 : 4'd0;
         3'd1: return 4'd2;
         3'd2: return 4'd3;
         3'd3: return 4'd4;
         3'd4: return 4'd5;
         3'd5: return alt ? 4'd7 : 4'd6;
         3'd6: return 4'd8;
         default: return 4'd9;
      endcase
   endfunction

   task automatic clear_ctl();
      {is_alu_reg, reg_write, is_jal, is_jalr, is_branch, is_lui, is_auipc} = '0;
      {is_load, is_store, is_shamt} = '0;
      alu_control = 4'd0;
   endtask

   // decode like an external control unit, predict from instruction semantics, run one cycle
   task automatic exec(input logic [31:0] ins, input logic [31:0] mrd);
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic        alt, wr, ck_alu, shift;
      logic [31:0] a, b, ii, is, ib, iu, ij, e_alu, e_wb, e_pc, e_wd;
      logic [3:0]  e_mask;
      rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20]; f3 = ins[14:12]; alt = ins[30];
      a = m_regs[rs1]; b = m_regs[rs2];
      ii = {{20{ins[31]}}, ins[31:20]};
      is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      iu = {ins[31:12], 12'd0};
      ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      clear_ctl();
      instr = ins; funct3 = f3; mem_rdata = mrd;
      e_pc = m_pc + 32'd4; e_alu = 32'd0; e_wb = 32'd0; e_wd = 32'd0; e_mask = 4'd0;
      wr = 1'b0; ck_alu = 1'b1; shift = (f3 == 3'd1) || (f3 == 3'd5);
      case (ins[6:0])
         7'h33: begin
            is_alu_reg = 1; reg_write = 1; wr = 1; alu_control = alu_code(f3, alt);
            e_alu = op_ref(f3, alt, a, b); e_wb = e_alu;
         end
         7'h13: begin
            reg_write = 1; wr = 1; is_shamt = shift; alu_control = alu_code(f3, alt && f3 == 3'd5);
            e_alu = op_ref(f3, alt && f3 == 3'd5, a, shift ? {27'd0, ins[24:20]} : ii); e_wb = e_alu;
         end
         7'h63: begin
            is_branch = 1; alu_control = 4'd1; e_alu = a - b;
            if (br_ref(f3, a, b)) e_pc = m_pc + ib;
         end
         7'h6f: begin
            is_jal = 1; reg_write = 1; wr = 1; ck_alu = 0; e_wb = m_pc + 32'd4; e_pc = m_pc + ij;
         end
         7'h67: begin
            is_jalr = 1; reg_write = 1; wr = 1; e_alu = a + ii; e_wb = m_pc + 32'd4;
            e_pc = {e_alu[31:1], 1'b0};
         end
         7'h37: begin is_lui = 1; reg_write = 1; wr = 1; ck_alu = 0; e_wb = iu; end
         7'h17: begin is_auipc = 1; reg_write = 1; wr = 1; ck_alu = 0; e_wb = m_pc + iu; end
         7'h03: begin
            is_load = 1; reg_write = 1; wr = 1; e_alu = a + ii; e_wb = ld_ref(f3, e_alu[1:0], mrd);
         end
         7'h23: begin
            is_store = 1; e_alu = a + is;
            if (f3 == 3'd0) begin e_mask = 4'd1 << e_alu[1:0]; e_wd = b << (8 * e_alu[1:0]); end
            else if (f3 == 3'd1) begin e_mask = e_alu[1] ? 4'hC : 4'h3; e_wd = b << (16 * e_alu[1]); end
            else begin e_mask = 4'hF; e_wd = b; end
         end
         default: ck_alu = 0;
      endcase
      #1;
      s_in1 = alu_in1; s_in2 = alu_in2; s_alu = alu_out; s_zero = is_zero;
      s_mask = mem_wmask; s_wd = mem_wdata;
      chk("alu_in1", alu_in1, a);
      chk("wmask", {28'd0, mem_wmask}, {28'd0, e_mask});
      if (ck_alu) begin
         chk("alu_out", alu_out, e_alu);
         chk("is_zero", {31'd0, is_zero}, {31'd0, e_alu == 32'd0});
      end
      if (is_store) chk("wdata", mem_wdata, e_wd);
      @(posedge clk); #1;
      if (wr && rd != 5'd0) m_regs[rd] = e_wb;
      m_pc = e_pc;
      chk("pc", pc, m_pc);
   endtask

   task automatic rd_reg(input logic [4:0] r);
      exec({12'd0, r, 3'd0, 5'd0, 7'h13}, 32'd0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic        alt;
      logic [31:0] r;
      logic [12:0] bi;
      logic [20:0] ji;
      rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      f3 = 3'($urandom_range(0, 7)); alt = 1'($urandom_range(0, 1));
      r = $urandom; bi = {r[12:1], 1'b0}; ji = {r[20:1], 1'b0};
      case ($urandom_range(0, 9))
         0, 1: return {1'b0, alt && (f3 == 3'd0 || f3 == 3'd5), 5'd0, rs2, rs1, f3, rd, 7'h33};
         2, 3: return (f3 == 3'd1 || f3 == 3'd5) ?
                      {1'b0, alt && f3 == 3'd5, 5'd0, r[24:20], rs1, f3, rd, 7'h13} :
                      {r[31:20], rs1, f3, rd, 7'h13};
         4: return {bi[12], bi[10:5], rs2, rs1, f3, bi[4:1], bi[11], 7'h63};
         5: return {ji[20], ji[10:1], ji[11], ji[19:12], rd, 7'h6f};
         6: return {r[31:20], rs1, 3'd0, rd, 7'h67};
         7: return {r[31:12], rd, alt ? 7'h37 : 7'h17};
         8: return {r[31:20], rs1, f3, rd, 7'h03};
         default: return {r[31:25], rs2, rs1, 3'($urandom_range(0, 2)), r[11:7], 7'h23};
      endcase
   endfunction

   initial begin
      logic [31:0] p;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pc = 32'd0;
      clear_ctl();
      rst_n = 1'b0; instr = 32'h0000_0013; funct3 = 3'd0; mem_rdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_pc", pc, 32'd0);
      instr = 32'h0000_8013;
      #1;
      chk("reset_x1", alu_in1, 32'd0);
      rst_n = 1'b1;
      repeat (3) exec(32'h0000_0013, 32'd0);
      chk("nop_pc12", pc, 32'd12);

      exec(32'h0050_0093, 32'd0);
      chk("addi_in2", s_in2, 32'd5);
      chk("addi_out", s_alu, 32'd5);
      chk("addi_nz", {31'd0, s_zero}, 32'd0);
      rd_reg(5'd1);
      chk("x1_is_5", s_in1, 32'd5);
      exec(32'h0050_0113, 32'd0);
      p = m_pc;
      exec(32'h0020_8463, 32'd0);
      chk("beq_zero", {31'd0, s_zero}, 32'd1);
      chk("beq_taken", pc, p + 32'd8);
      exec(32'h0060_0113, 32'd0);
      p = m_pc;
      exec(32'h0020_8463, 32'd0);
      chk("beq_not", pc, p + 32'd4);

      exec(32'h0200_0067, 32'd0);
      chk("jalr_20", pc, 32'h20);
      exec(32'h0100_00EF, 32'd0);
      chk("jal_30", pc, 32'h30);
      rd_reg(5'd1);
      chk("jal_link", s_in1, 32'h24);
      exec(32'h0000_8067, 32'd0);
      chk("jalr_24", pc, 32'h24);

      exec(32'h0AB0_0113, 32'd0);
      exec(32'h0020_00A3, 32'd0);
      chk("sb_addr", s_alu, 32'd1);
      chk("sb_mask", {28'd0, s_mask}, 32'h2);
      chk("sb_data", s_wd, 32'h0000_AB00);
      exec(32'h0020_2023, 32'd0);
      chk("sw_mask", {28'd0, s_mask}, 32'hF);
      exec(32'h0000_0013, 32'd0);
      chk("nost_mask", {28'd0, s_mask}, 32'h0);

      exec(32'h0030_0183, 32'h8000_0000);
      rd_reg(5'd3);
      chk("lb_sext", s_in1, 32'hFFFF_FF80);
      exec(32'h0030_4183, 32'h8000_0000);
      rd_reg(5'd3);
      chk("lbu_zext", s_in1, 32'h0000_0080);
      exec(32'h1234_5237, 32'd0);
      rd_reg(5'd4);
      chk("lui", s_in1, 32'h1234_5000);
      exec(32'h0070_0013, 32'd0);
      rd_reg(5'd0);
      chk("x0_zero", s_in1, 32'd0);

      for (int n = 0; n < 400; n++) exec(rand_instr(), $urandom);
      for (int r = 0; r < 32; r++) rd_reg(5'(r));

      exec(32'h0090_0293, 32'd0);
      clear_ctl();
      instr = 32'h0090_0293; reg_write = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async_pc", pc, 32'd0);
      @(posedge clk); #1;
      reg_write = 1'b0; instr = {12'd0, 5'd5, 3'd0, 5'd0, 7'h13};
      #1;
      chk("async_x5", alu_in1, 32'd0);
      chk("held_pc", pc, 32'd0);
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
